// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: stall requests and exception info flowing into the
// controller, and hold/flush/redirect plus statistics flowing back out.
// Signal suffixes are from the controller's point of view.
interface pipe_ctrl_if;
    logic        stallreq_if_i;
    logic        stallreq_id_i;
    logic        stallreq_ex_i;
    logic        stallreq_mem_i;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [31:0] stall_cycles_o;
    logic [31:0] exc_count_o;
    logic        stall_timeout_o;

    // Controller side.
    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  excepttype_i, cp0_epc_i,
        output stall_o, flush_o, new_pc_o,
        output stall_cycles_o, exc_count_o, stall_timeout_o
    );

    // Pipeline side.
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output excepttype_i, cp0_epc_i,
        input  stall_o, flush_o, new_pc_o,
        input  stall_cycles_o, exc_count_o, stall_timeout_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall generation by priority, exception
// sequencing (wait for data bus, freeze one cycle, flush with redirect PC),
// stall/exception statistics and a sticky stall watchdog.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);

    localparam logic [31:0] ERET_TYPE = 32'h0000000e;
    localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);
    localparam logic [5:0]  STALL_ALL = 6'b111111;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        FREEZE = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] exc_type_q, exc_type_d;
    logic [31:0] exc_epc_q, exc_epc_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] exc_count_q, exc_count_d;
    logic [31:0] run_cnt_q, run_cnt_d;
    logic        timeout_q, timeout_d;

    logic [5:0]  stall_s;
    logic        flush_s;
    logic [31:0] new_pc_s;
    logic        exc_s;

    // Highest stalled stage wins; it holds itself and every stage upstream.
    function automatic logic [5:0] stall_priority(input logic s_if, input logic s_id,
                                                  input logic s_ex, input logic s_mem);
        logic [5:0] v;
        if (s_mem) begin
            v = 6'b011111;
        end else if (s_ex) begin
            v = 6'b001111;
        end else if (s_id) begin
            v = 6'b000111;
        end else if (s_if) begin
            v = 6'b000011;
        end else begin
            v = 6'b000000;
        end
        return v;
    endfunction

    assign exc_s = (bus.excepttype_i != 32'h00000000);

    // Hold/flush/redirect outputs decoded from the current state and live inputs.
    always_comb begin
        stall_s  = 6'b000000;
        flush_s  = 1'b0;
        new_pc_s = 32'h00000000;
        case (state_q)
            RUN: begin
                if (exc_s) begin
                    stall_s = STALL_ALL;
                end else begin
                    stall_s = stall_priority(bus.stallreq_if_i, bus.stallreq_id_i,
                                             bus.stallreq_ex_i, bus.stallreq_mem_i);
                end
            end
            PEND: begin
                stall_s = STALL_ALL;
            end
            FREEZE: begin
                stall_s = STALL_ALL;
            end
            FLUSH: begin
                flush_s = 1'b1;
                if (exc_type_q == ERET_TYPE) begin
                    new_pc_s = exc_epc_q;
                end else begin
                    new_pc_s = EXC_VECTOR;
                end
            end
            default: begin
                stall_s = 6'b000000;
            end
        endcase
    end

    // Next-state for the exception sequencer, latched exception info and counters.
    always_comb begin
        state_d        = state_q;
        exc_type_d     = exc_type_q;
        exc_epc_d      = exc_epc_q;
        exc_count_d    = exc_count_q;
        stall_cycles_d = stall_cycles_q;
        run_cnt_d      = run_cnt_q;
        timeout_d      = timeout_q;

        case (state_q)
            RUN: begin
                if (exc_s) begin
                    exc_type_d = bus.excepttype_i;
                    exc_epc_d  = bus.cp0_epc_i;
                    // An in-flight data bus transfer is allowed to complete first.
                    if (bus.stallreq_mem_i) begin
                        state_d = PEND;
                    end else begin
                        state_d = FREEZE;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            PEND: begin
                if (!bus.stallreq_mem_i) begin
                    state_d = FREEZE;
                end else begin
                    state_d = PEND;
                end
            end
            FREEZE: begin
                state_d = FLUSH;
            end
            FLUSH: begin
                state_d     = RUN;
                exc_count_d = exc_count_q + 32'd1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (stall_s != 6'b000000) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
            if (run_cnt_q >= TIMEOUT_C) begin
                run_cnt_d = TIMEOUT_C;
            end else begin
                run_cnt_d = run_cnt_q + 32'd1;
            end
            if (run_cnt_d == TIMEOUT_C) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            run_cnt_d = 32'd0;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            exc_type_q     <= 32'd0;
            exc_epc_q      <= 32'd0;
            stall_cycles_q <= 32'd0;
            exc_count_q    <= 32'd0;
            run_cnt_q      <= 32'd0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            exc_type_q     <= exc_type_d;
            exc_epc_q      <= exc_epc_d;
            stall_cycles_q <= stall_cycles_d;
            exc_count_q    <= exc_count_d;
            run_cnt_q      <= run_cnt_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.stall_o         = stall_s;
    assign bus.flush_o         = flush_s;
    assign bus.new_pc_o        = new_pc_s;
    assign bus.stall_cycles_o  = stall_cycles_q;
    assign bus.exc_count_o     = exc_count_q;
    assign bus.stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the control rules.
module tb_pipe_ctrl;

    localparam logic [31:0] EXC_VEC = 32'h00000020;
    localparam int          TO      = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.EXC_VECTOR(EXC_VEC), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: phase 0 running, 1 waiting on bus, 2 frozen, 3 flushing.
    int          m_phase;
    logic [31:0] m_type, m_epc, m_cycles, m_exc;
    int          m_run;
    logic        m_to;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;

    // Apply one cycle of inputs after the falling edge and derive expected outputs.
    task automatic drive(input logic r, input logic [3:0] req, input logic [31:0] et,
                         input logic [31:0] epc);
        @(negedge clk);
        rst                = r;
        bus.stallreq_if_i  = req[0];
        bus.stallreq_id_i  = req[1];
        bus.stallreq_ex_i  = req[2];
        bus.stallreq_mem_i = req[3];
        bus.excepttype_i   = et;
        bus.cp0_epc_i      = epc;
        #1;
        e_stall = 6'b000000;
        e_flush = (m_phase == 3);
        e_pc    = 32'h0;
        if (m_phase == 3) begin
            e_pc = (m_type == 32'h0000000e) ? m_epc : EXC_VEC;
        end else if (m_phase != 0 || et != 32'h0) begin
            e_stall = 6'b111111;
        end else begin
            for (int i = 0; i < 4; i++)
                if (req[i]) e_stall = 6'((1 << (i + 2)) - 1);
        end
    endtask

    // Move the model across the coming rising edge.
    task automatic advance();
        if (rst) begin
            m_phase = 0; m_type = 32'h0; m_epc = 32'h0;
            m_cycles = 32'h0; m_exc = 32'h0; m_run = 0; m_to = 1'b0;
        end else begin
            if (e_stall != 6'b000000) begin
                m_cycles = m_cycles + 32'd1;
                m_run = (m_run < TO) ? m_run + 1 : TO;
                if (m_run == TO) m_to = 1'b1;
            end else begin
                m_run = 0;
            end
            case (m_phase)
                0: if (bus.excepttype_i != 32'h0) begin
                       m_type = bus.excepttype_i;
                       m_epc = bus.cp0_epc_i;
                       m_phase = bus.stallreq_mem_i ? 1 : 2;
                   end
                1: if (!bus.stallreq_mem_i) m_phase = 2;
                2: m_phase = 3;
                3: begin m_exc = m_exc + 32'd1; m_phase = 0; end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic do_reset();
        drive(1'b1, 4'($urandom), $urandom, $urandom);
        advance();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 4'b1111, 32'h8, $urandom);
        advance();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if (bus.stall_o !== 6'b000000) begin errors++; $display("FAIL reset_stall got %b exp 000000", bus.stall_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", bus.flush_o); end
        checks++; if (bus.new_pc_o !== 32'h0) begin errors++; $display("FAIL reset_new_pc got %h exp 0", bus.new_pc_o); end
        checks++; if (bus.stall_cycles_o !== 32'h0) begin errors++; $display("FAIL reset_stall_cycles got %h exp 0", bus.stall_cycles_o); end
        checks++; if (bus.exc_count_o !== 32'h0) begin errors++; $display("FAIL reset_exc_count got %h exp 0", bus.exc_count_o); end
        checks++; if (bus.stall_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus.stall_timeout_o); end
        advance();
    endtask

    task automatic test_stall_priority();
        logic [3:0] reqs [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1111, 4'b0110, 4'b0000};
        logic [5:0] exps [7] = '{6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b011111, 6'b001111, 6'b000000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, reqs[i], 32'h0, $urandom);
            checks++; if (bus.stall_o !== exps[i]) begin errors++; $display("FAIL prio_stall[%0d] got %b exp %b", i, bus.stall_o, exps[i]); end
            checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL prio_flush[%0d] got %b exp 0", i, bus.flush_o); end
            advance();
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0110, 32'h0, 32'h0);
            checks++; if (bus.stall_o !== 6'b001111) begin errors++; $display("FAIL ex_id_stall[%0d] got %b exp 001111", i, bus.stall_o); end
            advance();
        end
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if (bus.stall_cycles_o !== 32'd3) begin errors++; $display("FAIL ex_id_stall_cycles got %0d exp 3", bus.stall_cycles_o); end
        advance();
    endtask

    task automatic test_exception_vector();
        do_reset();
        drive(1'b0, 4'b0111, 32'h00000008, 32'h00005555);
        checks++; if (bus.stall_o !== 6'b111111) begin errors++; $display("FAIL exc_n_stall got %b exp 111111", bus.stall_o); end
        advance();
        drive(1'b0, 4'($urandom), $urandom, $urandom);
        checks++; if (bus.stall_o !== 6'b111111) begin errors++; $display("FAIL exc_n1_stall got %b exp 111111", bus.stall_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL exc_n1_flush got %b exp 0", bus.flush_o); end
        advance();
        drive(1'b0, 4'($urandom), $urandom, $urandom);
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL exc_n2_flush got %b exp 1", bus.flush_o); end
        checks++; if (bus.new_pc_o !== 32'h00000020) begin errors++; $display("FAIL exc_n2_new_pc got %h exp 00000020", bus.new_pc_o); end
        checks++; if (bus.stall_o !== 6'b000000) begin errors++; $display("FAIL exc_n2_stall got %b exp 000000", bus.stall_o); end
        advance();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if (bus.exc_count_o !== 32'd1) begin errors++; $display("FAIL exc_count got %0d exp 1", bus.exc_count_o); end
        checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL exc_n3_flush got %b exp 0", bus.flush_o); end
        advance();
    endtask

    task automatic test_eret_pending();
        do_reset();
        // Memory busy at N, N+1, N+2; free from N+3.
        for (int c = 0; c < 5; c++) begin
            if (c == 0)      drive(1'b0, 4'b1000, 32'h0000000e, 32'h00001234);
            else if (c < 3)  drive(1'b0, 4'b1000, $urandom, $urandom);
            else if (c == 3) drive(1'b0, 4'b0000, $urandom, $urandom);
            else             drive(1'b0, 4'($urandom), $urandom, $urandom);
            checks++; if (bus.stall_o !== 6'b111111) begin errors++; $display("FAIL eret_stall[N+%0d] got %b exp 111111", c, bus.stall_o); end
            checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL eret_flush[N+%0d] got %b exp 0", c, bus.flush_o); end
            checks++; if (bus.new_pc_o !== 32'h0) begin errors++; $display("FAIL eret_pc[N+%0d] got %h exp 0", c, bus.new_pc_o); end
            advance();
        end
        drive(1'b0, 4'($urandom), $urandom, $urandom);
        checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL eret_flush[N+5] got %b exp 1", bus.flush_o); end
        checks++; if (bus.new_pc_o !== 32'h00001234) begin errors++; $display("FAIL eret_new_pc got %h exp 00001234", bus.new_pc_o); end
        advance();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, (c == 3 || c == 7) ? 4'b0000 : 4'b0001, 32'h0, 32'h0);
            advance();
        end
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if (bus.stall_timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", bus.stall_timeout_o); end
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 4'b0001, 32'h0, 32'h0);
            checks++; if (bus.stall_timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_pre[%0d] got %b exp 0", c, bus.stall_timeout_o); end
            advance();
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'b0000, 32'h0, 32'h0);
            checks++; if (bus.stall_timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky[%0d] got %b exp 1", c, bus.stall_timeout_o); end
            advance();
        end
    endtask

    task automatic test_reset_mid_sequence();
        for (int v = 0; v < 2; v++) begin
            do_reset();
            drive(1'b0, (v == 0) ? 4'b0000 : 4'b1000, 32'h00000008, $urandom);
            advance();
            drive(1'b1, 4'($urandom), $urandom, $urandom);
            advance();
            for (int c = 0; c < 3; c++) begin
                drive(1'b0, 4'b0000, 32'h0, 32'h0);
                checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rst_seq_flush[%0d/%0d] got %b exp 0", v, c, bus.flush_o); end
                checks++; if (bus.stall_o !== 6'b000000) begin errors++; $display("FAIL rst_seq_stall[%0d/%0d] got %b exp 000000", v, c, bus.stall_o); end
                checks++; if (bus.exc_count_o !== 32'h0) begin errors++; $display("FAIL rst_seq_exc_count[%0d/%0d] got %0d exp 0", v, c, bus.exc_count_o); end
                advance();
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b0, 4'b0001, 32'h0, 32'h0);
        force dut.stall_cycles_q = 32'hFFFFFFFF;
        #1 release dut.stall_cycles_q;
        m_cycles = 32'hFFFFFFFF;
        advance();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if (bus.stall_cycles_o !== 32'h0) begin errors++; $display("FAIL wrap_stall_cycles got %h exp 00000000", bus.stall_cycles_o); end
        advance();
        drive(1'b0, 4'b0100, 32'h0, 32'h0);
        advance();
        drive(1'b0, 4'b0000, 32'h0, 32'h0);
        checks++; if (bus.stall_cycles_o !== 32'h1) begin errors++; $display("FAIL wrap_next got %h exp 00000001", bus.stall_cycles_o); end
        advance();
    endtask

    task automatic test_random();
        logic        r;
        logic [31:0] et;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            r  = ($urandom_range(0, 59) == 0);
            et = 32'h0;
            if ($urandom_range(0, 6) == 0) et = $urandom_range(0, 1) ? 32'h0000000e : $urandom;
            drive(r, 4'($urandom), et, $urandom);
            if (!r) begin
                checks++; if (bus.stall_o !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d] got %b exp %b", c, bus.stall_o, e_stall); end
                checks++; if (bus.flush_o !== e_flush) begin errors++; $display("FAIL rnd_flush[%0d] got %b exp %b", c, bus.flush_o, e_flush); end
                checks++; if (bus.new_pc_o !== e_pc) begin errors++; $display("FAIL rnd_new_pc[%0d] got %h exp %h", c, bus.new_pc_o, e_pc); end
            end
            checks++; if (bus.stall_cycles_o !== m_cycles) begin errors++; $display("FAIL rnd_stall_cycles[%0d] got %h exp %h", c, bus.stall_cycles_o, m_cycles); end
            checks++; if (bus.exc_count_o !== m_exc) begin errors++; $display("FAIL rnd_exc_count[%0d] got %h exp %h", c, bus.exc_count_o, m_exc); end
            checks++; if (bus.stall_timeout_o !== m_to) begin errors++; $display("FAIL rnd_timeout[%0d] got %b exp %b", c, bus.stall_timeout_o, m_to); end
            advance();
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.stallreq_if_i = 1'b0; bus.stallreq_id_i = 1'b0;
        bus.stallreq_ex_i = 1'b0; bus.stallreq_mem_i = 1'b0;
        bus.excepttype_i = 32'h0; bus.cp0_epc_i = 32'h0;
        m_phase = 0; m_type = 32'h0; m_epc = 32'h0; m_cycles = 32'h0;
        m_exc = 32'h0; m_run = 0; m_to = 1'b0;
        e_stall = 6'b0; e_flush = 1'b0; e_pc = 32'h0;
        test_reset();
        test_stall_priority();
        test_exception_vector();
        test_eret_pending();
        test_timeout();
        test_reset_mid_sequence();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
